// File: rtl/div_pkg.sv
// Shared widths, FSM state type and the single restoring-division step
// used by seq_divider.
package div_pkg;

   localparam int DIVIDEND_W = 32;
   localparam int DIVISOR_W  = 16;
   localparam int ITER       = 16;
   localparam int CNT_W      = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic [DIVISOR_W:0]   rem;
      logic [DIVISOR_W-1:0] quo;
   } div_step_t;

   // One restoring iteration: shift {rem, quo} left, keep the trial
   // subtraction only when it does not go negative.
   function automatic div_step_t div_step(input logic [DIVISOR_W:0]   rem,
                                          input logic [DIVISOR_W-1:0] quo,
                                          input logic [DIVISOR_W-1:0] dvs);
      logic [DIVISOR_W:0]   rem_sh;
      logic [DIVISOR_W-1:0] quo_sh;
      logic [DIVISOR_W+1:0] trial;
      {rem_sh, quo_sh} = {rem, quo} << 1;
      trial = {1'b0, rem_sh} - {2'b00, dvs};
      div_step.quo = quo_sh | {{(DIVISOR_W-1){1'b0}}, ~trial[DIVISOR_W+1]};
      div_step.rem = trial[DIVISOR_W+1] ? rem_sh : trial[DIVISOR_W:0];
   endfunction

endpackage

// File: rtl/div_counter.sv
// Iteration counter for seq_divider: clear wins over enable, terminal
// flags the last iteration.
module div_counter
   import div_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic terminal
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign terminal = (count_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/seq_divider.sv
// 32/16 restoring sequential divider, one quotient bit per cycle.
// Define DIV_ERR_CHECK_EN to add divide-by-zero / overflow early exit.
module seq_divider
   import div_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVISOR_W-1:0]  quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  overflow
);

   div_state_e           state_q, state_d;
   logic [DIVISOR_W:0]   rem_q, rem_d;
   logic [DIVISOR_W-1:0] qsh_q, qsh_d;
   logic [DIVISOR_W-1:0] dvs_q, dvs_d;
   logic [DIVISOR_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0] remainder_q, remainder_d;
   logic                 done_q, done_d;
   logic                 cnt_clr, cnt_en, cnt_term;
   div_step_t            step;
`ifdef DIV_ERR_CHECK_EN
   logic                 dbz_q, dbz_d;
   logic                 ovf_q, ovf_d;
`endif

   div_counter u_counter (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .terminal (cnt_term)
   );

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      qsh_d       = qsh_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = 1'b0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
`ifdef DIV_ERR_CHECK_EN
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
`endif
      step = div_step(rem_q, qsh_q, dvs_q);

      case (state_q)
         IDLE: begin
            if (start) begin
               dvs_d   = divisor;
               rem_d   = {1'b0, dividend[DIVIDEND_W-1:DIVISOR_W]};
               qsh_d   = dividend[DIVISOR_W-1:0];
               cnt_clr = 1'b1;
               state_d = RUN;
`ifdef DIV_ERR_CHECK_EN
               // Error cases skip the iterations and report in the next cycle.
               if (divisor == '0) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  quotient_d  = '1;
                  remainder_d = dividend[DIVISOR_W-1:0];
                  dbz_d       = 1'b1;
                  ovf_d       = 1'b0;
               end else if (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  quotient_d  = '1;
                  remainder_d = '1;
                  dbz_d       = 1'b0;
                  ovf_d       = 1'b1;
               end
`endif
            end
         end
         RUN: begin
            cnt_en = 1'b1;
            rem_d  = step.rem;
            qsh_d  = step.quo;
            if (cnt_term) begin
               state_d     = DONE;
               done_d      = 1'b1;
               quotient_d  = step.quo;
               remainder_d = step.rem[DIVISOR_W-1:0];
`ifdef DIV_ERR_CHECK_EN
               dbz_d       = 1'b0;
               ovf_d       = 1'b0;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         qsh_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
`ifdef DIV_ERR_CHECK_EN
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         qsh_q       <= qsh_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
`ifdef DIV_ERR_CHECK_EN
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
`ifdef DIV_ERR_CHECK_EN
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
`else
   assign div_by_zero = 1'b0;
   assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, results, start-ignore,
// reset abort and (with DIV_ERR_CHECK_EN) the early error exits.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_divider dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " done"}, 32'(done), 0);
      chk({tag, " quotient"}, 32'(quotient), 0);
      chk({tag, " remainder"}, 32'(remainder), 0);
      chk({tag, " div_by_zero"}, 32'(div_by_zero), 0);
      chk({tag, " overflow"}, 32'(overflow), 0);
   endtask

   // Waits from cycle cyc_in until done, checking busy beforehand.
   task automatic wait_done(input string tag, input int cyc_in, input int exp_cyc);
      int cyc;
      bit busy_ok;
      cyc     = cyc_in;
      busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         tick();
         cyc++;
      end
      chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, " busy_before_done"}, 32'(busy_ok), 1);
      chk({tag, " busy_at_done"}, 32'(busy), 0);
   endtask

   task automatic chk_result(input string tag, input logic [15:0] eq, input logic [15:0] er,
                             input logic ez, input logic eo);
      chk({tag, " quotient"}, 32'(quotient), 32'(eq));
      chk({tag, " remainder"}, 32'(remainder), 32'(er));
      chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
      chk({tag, " overflow"}, 32'(overflow), 32'(eo));
   endtask

   task automatic run_op(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                         input int exp_cyc, input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input logic eo);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
      wait_done(tag, 1, exp_cyc);
      chk_result(tag, eq, er, ez, eo);
      tick();
      chk({tag, " done_one_cycle"}, 32'(done), 0);
      tick();
      tick();
      chk({tag, " hold_quotient"}, 32'(quotient), 32'(eq));
      chk({tag, " hold_remainder"}, 32'(remainder), 32'(er));
   endtask

   initial begin
      int pulses;
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      chk_idle_zero("reset");
      reset = 1'b0;
      tick();

      run_op("div_100000_7", 32'd100000, 16'd7, 17, 16'd14285, 16'd5, 1'b0, 1'b0);
      run_op("div_max", 32'hFFFEFFFF, 16'hFFFF, 17, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
      run_op("div_exact", 32'd1000, 16'd1000, 17, 16'd1, 16'd0, 1'b0, 1'b0);
      run_op("div_small", 32'd5, 16'd10, 17, 16'd0, 16'd5, 1'b0, 1'b0);

`ifdef DIV_ERR_CHECK_EN
      run_op("div_zero", 32'h00001234, 16'd0, 1, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
      run_op("div_ovf", 32'h00070000, 16'd7, 1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      run_op("flags_clear", 32'd100, 16'd3, 17, 16'd33, 16'd1, 1'b0, 1'b0);
`else
      run_op("div_zero_nochk", 32'h00001234, 16'd0, 17, 16'hFFFF, 16'h1234, 1'b0, 1'b0);
      run_op("div_ovf_nochk", 32'h00070000, 16'd7, 17, 16'hFFFF, 16'd7, 1'b0, 1'b0);
`endif

      // Second start in cycle 5 must be ignored.
      dividend = 32'd100000;
      divisor  = 16'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      dividend = 32'd50;
      divisor  = 16'd5;
      start    = 1'b1;
      tick();
      start = 1'b0;
      wait_done("restart_ignored", 6, 17);
      chk_result("restart_ignored", 16'd14285, 16'd5, 1'b0, 1'b0);
      tick();

      // Reset in cycle 8 of RUN aborts the operation.
      dividend = 32'd1000;
      divisor  = 16'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b1;
      tick();
      chk_idle_zero("reset_abort");
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      chk("reset_abort no_done", 32'(pulses), 0);
      run_op("after_reset", 32'd1000, 16'd3, 17, 16'd333, 16'd1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; accepted only in IDLE.
REQ-004 SHALL have port dividend, input, 32 bits: unsigned dividend, sampled on accepted start.
REQ-005 SHALL have port divisor, input, 16 bits: unsigned divisor, sampled on accepted start.
REQ-006 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-008 SHALL have port quotient, output, 16 bits: registered quotient.
REQ-009 SHALL have port remainder, output, 16 bits: registered remainder.
REQ-010 SHALL have port div_by_zero, output, 1 bit: error flag for the last completed operation.
REQ-011 SHALL have port overflow, output, 1 bit: error flag, set when the quotient exceeds 16 bits.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE; reset state IDLE.
REQ-013 IDLE with start=1 SHALL capture the operands, clear iteration count to 0, and go to RUN; start is ignored in RUN and DONE.
REQ-014 The operand capture SHALL load the 17-bit partial remainder with {1'b0, dividend[31:16]} and the 16-bit quotient shift register with dividend[15:0].
REQ-015 Each RUN cycle SHALL perform one restoring step: shift {partial remainder, quotient register} left by 1; compute trial = partial remainder - divisor; if trial is non-negative, load the partial remainder with trial and set the quotient LSB to 1.
REQ-016 RUN SHALL last exactly 16 cycles, counted 0..15; on count 15 the FSM SHALL go to DONE.
REQ-017 On entry to DONE, quotient and remainder SHALL be loaded with the results; done=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-018 Latency SHALL be: start sampled at edge 0, busy high in cycles 1-16, done high in cycle 17.
REQ-019 quotient, remainder and the error flags SHALL hold their values until the next DONE.
REQ-020 Operand changes after the accepting edge SHALL NOT affect the result.
REQ-021 For any dividend/divisor with dividend[31:16] < divisor, the result SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-022 reset SHALL take priority over all other inputs and may abort an operation at any point.
REQ-023 One cycle after reset asserts, the block SHALL be in IDLE with busy, done, quotient, remainder, div_by_zero and overflow all 0; internal registers SHALL be 0.

Configuration
REQ-024 Macro DIV_ERR_CHECK_EN, when defined, SHALL enable the divide-by-zero and overflow checks performed on an accepted start.
REQ-025 With DIV_ERR_CHECK_EN defined and divisor==0: the FSM SHALL go directly to DONE (done in cycle 1), with quotient=16'hFFFF, remainder=dividend[15:0], div_by_zero=1, overflow=0.
REQ-026 With DIV_ERR_CHECK_EN defined and divisor!=0 with dividend[31:16]>=divisor: the FSM SHALL go directly to DONE, with quotient=16'hFFFF, remainder=16'hFFFF, overflow=1, div_by_zero=0.
REQ-027 Without DIV_ERR_CHECK_EN: div_by_zero and overflow SHALL be constant 0; every operation SHALL take the full 16 iterations; the outputs SHALL be whatever REQ-015 produces.

Structure
REQ-028 A shared package div_pkg SHALL define DIVIDEND_W=32, DIVISOR_W=16, ITER=16 and the FSM state enum typedef.
REQ-029 The iteration count SHALL live in a sub-module div_counter: 4-bit counter with clear and enable inputs, and a terminal output asserted at count 15.

Verification
REQ-030 Bench SHALL cover: dividend=100000, divisor=7 -> done in cycle 17, quotient=14285, remainder=5, both flags 0.
REQ-031 Bench SHALL cover: dividend=32'hFFFEFFFF, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=16'hFFFE.
REQ-032 Bench SHALL cover: with DIV_ERR_CHECK_EN, divisor=0, dividend=32'h00001234 -> done in cycle 1, quotient=16'hFFFF, remainder=16'h1234, div_by_zero=1.
REQ-033 Bench SHALL cover: with DIV_ERR_CHECK_EN, dividend=32'h00070000, divisor=7 -> done in cycle 1, overflow=1, quotient=remainder=16'hFFFF.
REQ-034 Bench SHALL cover: start pulsed again in cycle 5 with new operands -> ignored; the first result is delivered in cycle 17.
REQ-035 Bench SHALL cover: reset asserted in cycle 8 of RUN -> next cycle busy=0, outputs 0, no done pulse; a new start then completes normally.
